bundle_add_arbiter: RTL and testbench



---
 rtl/bundle_add_arb_pkg.sv | 25 ++
 rtl/bundle_add_rr_pick.sv | 50 +++++
 rtl/bundle_add_arbiter.sv | 141 ++++++++++++++
 tb/tb_bundle_add_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bundle_add_arb_pkg.sv
// ---------------------------------------------------------------------------
// bundle_add_arb_pkg
// Shared types and helpers for the bundle_add_arbiter block:
//   state_e   - output register state (ST_IDLE empty, ST_FULL holding a result)
//   idw(n)    - index width for n requesters (clog2, minimum 1)
//   DEF_NREQ  - default requester count
//   DEF_WIDTH - default operand / sum width
// ---------------------------------------------------------------------------
package bundle_add_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FULL = 1'b1
   } state_e;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 4;

   function automatic int idw(input int n);
      int w;
      w = (n > 1) ? $clog2(n) : 1;
      return w;
   endfunction

endpackage

// File: rtl/bundle_add_rr_pick.sv
// ---------------------------------------------------------------------------
// bundle_add_rr_pick
// Combinational round-robin picker. Searches req starting at ptr, then
// ptr+1, ... wrapping NREQ-1 -> 0, and reports the first set bit.
// Ports:
//   req       in  NREQ  request vector
//   ptr       in  IDW   highest-priority index this cycle (must be < NREQ)
//   grant     out NREQ  one-hot grant (all zero when nothing requests)
//   idx       out IDW   index of the granted requester (0 when none)
//   any_valid out 1     at least one request present
// ---------------------------------------------------------------------------
module bundle_add_rr_pick
   import bundle_add_arb_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   localparam int IDW  = idw(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any_valid
);

   logic [IDW:0]   cand_s;
   logic [IDW-1:0] cand;

   always_comb begin
      grant     = '0;
      idx       = '0;
      any_valid = 1'b0;
      cand_s    = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         // One extra bit so ptr+k cannot overflow before the explicit wrap,
         // which also handles NREQ that is not a power of two.
         cand_s = {1'b0, ptr} + (IDW+1)'(k);
         if (cand_s >= (IDW+1)'(NREQ)) begin
            cand_s = cand_s - (IDW+1)'(NREQ);
         end
         cand = cand_s[IDW-1:0];
         if (!any_valid && req[cand]) begin
            grant[cand] = 1'b1;
            idx         = cand;
            any_valid   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bundle_add_arbiter.sv
// ---------------------------------------------------------------------------
// bundle_add_arbiter
// Shares one registered WIDTH-bit adder between NREQ requesters. Requesters
// are granted round-robin; the sum (and requester id) is returned one cycle
// after acceptance on a single valid/ready response port. A held result may
// drain and a new one be accepted in the same cycle, giving one result per
// cycle under continuous demand.
//
// Optional feature: define BUNDLE_ADD_ARB_CARRY_EN to add resp_carry, the
// registered carry-out of in1+in2.
//
// Ports:
//   clock      in  1           rising-edge clock
//   reset      in  1           asynchronous active-high reset
//   req_valid  in  NREQ        requester i presents operands
//   req_ready  out NREQ        requester i accepted this cycle (one-hot or 0)
//   req_in1    in  NREQ*WIDTH  operand 1, requester i at [i*WIDTH +: WIDTH]
//   req_in2    in  NREQ*WIDTH  operand 2, same packing
//   resp_valid out 1           output register holds a result
//   resp_ready in  1           consumer takes the result
//   resp_sum   out WIDTH       (in1+in2) mod 2^WIDTH
//   resp_id    out IDW         requester that produced resp_sum
//   resp_carry out 1           carry-out (BUNDLE_ADD_ARB_CARRY_EN only)
// ---------------------------------------------------------------------------
module bundle_add_arbiter
   import bundle_add_arb_pkg::*;
#(
   parameter  int NREQ  = DEF_NREQ,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int IDW   = idw(NREQ)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_in1,
   input  logic [NREQ*WIDTH-1:0] req_in2,
   output logic                  resp_valid,
   input  logic                  resp_ready,
`ifdef BUNDLE_ADD_ARB_CARRY_EN
   output logic                  resp_carry,
`endif
   output logic [WIDTH-1:0]      resp_sum,
   output logic [IDW-1:0]        resp_id
);

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [IDW-1:0]   id_q, id_d;
`ifdef BUNDLE_ADD_ARB_CARRY_EN
   logic             carry_q, carry_d;
`endif

   logic [NREQ-1:0]  pick_grant;
   logic [IDW-1:0]   pick_idx;
   logic             pick_any;
   logic             can_accept;
   logic             accept;

   logic [WIDTH-1:0] in1_arr [NREQ];
   logic [WIDTH-1:0] in2_arr [NREQ];
   logic [WIDTH-1:0] op1, op2;

   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_unpack
         assign in1_arr[i] = req_in1[i*WIDTH +: WIDTH];
         assign in2_arr[i] = req_in2[i*WIDTH +: WIDTH];
      end
   endgenerate

   bundle_add_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (pick_grant),
      .idx       (pick_idx),
      .any_valid (pick_any)
   );

   // Gating with reset keeps req_ready low while reset is held, so no
   // requester believes a handshake completed that the flops will discard.
   assign can_accept = !reset && ((state_q == ST_IDLE) || resp_ready);
   assign accept     = pick_any && can_accept;
   assign req_ready  = can_accept ? pick_grant : '0;

   assign op1 = in1_arr[pick_idx];
   assign op2 = in2_arr[pick_idx];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sum_d   = sum_q;
      id_d    = id_q;
`ifdef BUNDLE_ADD_ARB_CARRY_EN
      carry_d = carry_q;
`endif
      if (accept) begin
`ifdef BUNDLE_ADD_ARB_CARRY_EN
         {carry_d, sum_d} = {1'b0, op1} + {1'b0, op2};
`else
         sum_d = op1 + op2;
`endif
         id_d    = pick_idx;
         state_d = ST_FULL;
         ptr_d   = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
      end else if ((state_q == ST_FULL) && resp_ready) begin
         // Drained with nothing to refill: data registers keep old values.
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         sum_q   <= '0;
         id_q    <= '0;
`ifdef BUNDLE_ADD_ARB_CARRY_EN
         carry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sum_q   <= sum_d;
         id_q    <= id_d;
`ifdef BUNDLE_ADD_ARB_CARRY_EN
         carry_q <= carry_d;
`endif
      end
   end

   assign resp_valid = (state_q == ST_FULL);
   assign resp_sum   = sum_q;
   assign resp_id    = id_q;
`ifdef BUNDLE_ADD_ARB_CARRY_EN
   assign resp_carry = carry_q;
`endif

endmodule

// File: tb/tb_bundle_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bundle_add_arbiter
// Self-checking bench for bundle_add_arbiter (NREQ=4, WIDTH=4) with a
// behavioural reference model of the arbiter kept in plain integers.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bundle_add_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int IDW   = 2;

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_in1 = '0;
   logic [NREQ*WIDTH-1:0] req_in2 = '0;
   logic                  resp_valid;
   logic                  resp_ready = 1'b0;
   logic [WIDTH-1:0]      resp_sum;
   logic [IDW-1:0]        resp_id;
`ifdef BUNDLE_ADD_ARB_CARRY_EN
   logic                  resp_carry;
`endif

   bundle_add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_in1    (req_in1),
      .req_in2    (req_in2),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
`ifdef BUNDLE_ADD_ARB_CARRY_EN
      .resp_carry (resp_carry),
`endif
      .resp_sum   (resp_sum),
      .resp_id    (resp_id)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   int m_full  = 0;
   int m_sum   = 0;
   int m_id    = 0;
   int m_ptr   = 0;
   int m_carry = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int opnd(input logic [NREQ*WIDTH-1:0] v, input int i);
      return int'((v >> (i*WIDTH)) & ((1 << WIDTH) - 1));
   endfunction

   // First valid requester looking from ptr onward, -1 if none.
   function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_full = 0; m_sum = 0; m_id = 0; m_ptr = 0; m_carry = 0;
   endtask

   // One cycle: drive, check req_ready mid-cycle, clock, update model, check outputs.
   // Called just after a rising edge.
   task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] a,
                       input logic [NREQ*WIDTH-1:0] b, input logic rr);
      int g;
      int can;
      int total;
      logic [NREQ-1:0] exp_rdy;
      req_valid  = v;
      req_in1    = a;
      req_in2    = b;
      resp_ready = rr;
      @(negedge clock);
      g   = model_grant(v, m_ptr);
      can = (m_full == 0) || rr;
      exp_rdy = (g >= 0 && can != 0) ? NREQ'(1 << g) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clock);
      if (g >= 0 && can != 0) begin
         total   = opnd(a, g) + opnd(b, g);
         m_sum   = total % (1 << WIDTH);
         m_carry = total >> WIDTH;
         m_id    = g;
         m_full  = 1;
         m_ptr   = (g + 1) % NREQ;
      end else if (m_full != 0 && rr) begin
         m_full = 0;
      end
      #1;
      check("resp_valid", 32'(resp_valid), 32'(m_full));
      check("resp_sum", 32'(resp_sum), 32'(m_sum));
      check("resp_id", 32'(resp_id), 32'(m_id));
`ifdef BUNDLE_ADD_ARB_CARRY_EN
      check("resp_carry", 32'(resp_carry), 32'(m_carry));
`endif
   endtask

   function automatic logic [NREQ*WIDTH-1:0] put(input int i, input int val);
      logic [NREQ*WIDTH-1:0] r;
      r = '0;
      r[i*WIDTH +: WIDTH] = WIDTH'(val);
      return r;
   endfunction

   initial begin
      int fair_ids [5];
      logic [NREQ*WIDTH-1:0] ra, rb;
      fair_ids = '{0, 1, 2, 3, 0};

      // Reset state, including req_ready held low while reset is active
      req_valid = '1;
      #12;
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_sum", 32'(resp_sum), 32'd0);
      check("rst_id", 32'(resp_id), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      @(posedge clock); #1;

      // Single request 3+5
      step(4'b0001, put(0, 3), put(0, 5), 1'b1);
      check("single_sum", 32'(resp_sum), 32'd8);
      check("single_id", 32'(resp_id), 32'd0);

      // Overflow 9+9 on requester 1 (ptr is 1)
      step(4'b0010, put(1, 9), put(1, 9), 1'b1);
      check("ovf_sum", 32'(resp_sum), 32'd2);
`ifdef BUNDLE_ADD_ARB_CARRY_EN
      check("ovf_carry", 32'(resp_carry), 32'd1);
`endif
      step(4'b0000, '0, '0, 1'b1);

      // Fairness from ptr 0 after a reset
      reset = 1'b1; #1; reset = 1'b0; model_reset();
      @(posedge clock); #1;
      for (int k = 0; k < 5; k++) begin
         step(4'b1111, 16'h4321, 16'h1111, 1'b1);
         check("fair_id", 32'(resp_id), 32'(fair_ids[k]));
         check("fair_valid", 32'(resp_valid), 32'd1);
      end

      // Backpressure: FULL with sum 7, id 2 (ptr is 1; only 2 requests)
      step(4'b0100, put(2, 3), put(2, 4), 1'b1);
      check("bp_setup_sum", 32'(resp_sum), 32'd7);
      for (int k = 0; k < 3; k++) begin
         step(4'b1111, 16'h5555, 16'h5555, 1'b0);
         check("bp_hold_sum", 32'(resp_sum), 32'd7);
         check("bp_hold_id", 32'(resp_id), 32'd2);
      end
      step(4'b1111, 16'h5555, 16'h5555, 1'b1);
      check("bp_next_id", 32'(resp_id), 32'd3);

      // Pointer skip / wrap: reach ptr 3, then 0101 grants 0 then 2
      step(4'b0100, '0, '0, 1'b1);
      step(4'b0101, 16'h0201, 16'h0101, 1'b1);
      check("skip_id0", 32'(resp_id), 32'd0);
      step(4'b0101, 16'h0201, 16'h0101, 1'b1);
      check("skip_id2", 32'(resp_id), 32'd2);

      // Asynchronous reset between edges while FULL
      req_valid = '0; resp_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("arst_valid", 32'(resp_valid), 32'd0);
      check("arst_sum", 32'(resp_sum), 32'd0);
      check("arst_id", 32'(resp_id), 32'd0);
      model_reset();
      #1; reset = 1'b0;
      @(posedge clock); #1;
      step(4'b1010, 16'h1111, 16'h1111, 1'b1);
      check("arst_first_id", 32'(resp_id), 32'd1);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         ra = NREQ*WIDTH'($urandom);
         rb = NREQ*WIDTH'($urandom);
         step(NREQ'($urandom), ra, rb, ($urandom_range(0, 3) != 0));
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   // Hard stop in case the stimulus never completes
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
